// File: rtl/arduino_mem_loader.sv
// Byte-serial loader: a host strobes opcode/argument bytes that select one of four
// memory banks, set a 14-bit address, and write or read single bytes with auto-increment.
module arduino_mem_loader (
   input  logic        sysclk,
   input  logic        arduino_reset,
   input  logic        arduino_strobe,
   input  logic [7:0]  arduino_din,
   output logic        arduino_ack,
   output logic [7:0]  arduino_dout,
   output logic        loader_error,

   input  logic [7:0]  mem_src_dout,
   output logic [7:0]  mem_src_din,
   output logic [13:0] mem_src_ad,
   output logic        mem_src_ce,
   output logic        mem_src_wre,
   output logic        mem_src_oce,
   output logic        mem_src_clk,

   input  logic [7:0]  mem_key_dout,
   output logic [7:0]  mem_key_din,
   output logic [13:0] mem_key_ad,
   output logic        mem_key_ce,
   output logic        mem_key_wre,
   output logic        mem_key_oce,
   output logic        mem_key_clk,

   input  logic [7:0]  mem_cmd_dout,
   output logic [7:0]  mem_cmd_din,
   output logic [13:0] mem_cmd_ad,
   output logic        mem_cmd_ce,
   output logic        mem_cmd_wre,
   output logic        mem_cmd_oce,
   output logic        mem_cmd_clk,

   input  logic [7:0]  mem_dst_dout,
   output logic [7:0]  mem_dst_din,
   output logic [13:0] mem_dst_ad,
   output logic        mem_dst_ce,
   output logic        mem_dst_wre,
   output logic        mem_dst_oce,
   output logic        mem_dst_clk
);

   localparam int unsigned DW = 8;
   localparam int unsigned AW = 14;
   localparam int unsigned NB = 4;

   typedef enum logic [2:0] {
      S_IDLE, S_DECODE, S_MEM_SETUP, S_MEM_CLKH, S_MEM_CLKL, S_ACK
   } state_t;

   typedef enum logic [2:0] {
      P_OP, P_BANK, P_ADDR_HI, P_ADDR_LO, P_WDATA
   } parse_t;

   logic strobe_meta, strobe_sync;

   state_t              state_q, state_n;
   parse_t              parse_q, parse_n;
   logic [DW-1:0]       byte_q, byte_n;
   logic [1:0]          bank_q, bank_n;
   logic [AW-1:0]       addr_q, addr_n;
   logic                read_q, read_n;
   logic                ack_q, ack_n;
   logic [DW-1:0]       dout_q, dout_n;
   logic                err_q, err_n;
   logic [NB-1:0]       ce_q, ce_n, wre_q, wre_n, oce_q, oce_n, mclk_q, mclk_n;
   logic [NB-1:0][AW-1:0] ad_q, ad_n;
   logic [NB-1:0][DW-1:0] din_q, din_n;
   logic [DW-1:0]       rd_data;
   logic                mem_go;

   always_comb begin
      unique case (bank_q)
         2'd0:    rd_data = mem_src_dout;
         2'd1:    rd_data = mem_key_dout;
         2'd2:    rd_data = mem_cmd_dout;
         default: rd_data = mem_dst_dout;
      endcase
   end

   // Next-state, byte parser and registered-output next values
   always_comb begin
      state_n = state_q;
      parse_n = parse_q;
      byte_n  = byte_q;
      bank_n  = bank_q;
      addr_n  = addr_q;
      read_n  = read_q;
      ack_n   = ack_q;
      dout_n  = dout_q;
      err_n   = err_q;
      ce_n    = ce_q;
      wre_n   = wre_q;
      oce_n   = oce_q;
      mclk_n  = mclk_q;
      ad_n    = ad_q;
      din_n   = din_q;
      mem_go  = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (strobe_sync) begin
               byte_n  = arduino_din;
               state_n = S_DECODE;
            end
         end
         S_DECODE: begin
            unique case (parse_q)
               P_OP: begin
                  unique case (byte_q)
                     8'h00: ;
                     8'h01: err_n = 1'b0;
                     8'h10: parse_n = P_BANK;
                     8'h20: parse_n = P_ADDR_HI;
                     8'h30: parse_n = P_WDATA;
                     8'h40: begin
                        mem_go = 1'b1;
                        read_n = 1'b1;
                     end
                     default: err_n = 1'b1;
                  endcase
               end
               P_BANK: begin
                  bank_n  = byte_q[1:0];
                  parse_n = P_OP;
               end
               P_ADDR_HI: begin
                  addr_n[AW-1:8] = byte_q[5:0];
                  parse_n        = P_ADDR_LO;
               end
               P_ADDR_LO: begin
                  addr_n[7:0] = byte_q;
                  parse_n     = P_OP;
               end
               P_WDATA: begin
                  mem_go  = 1'b1;
                  read_n  = 1'b0;
                  parse_n = P_OP;
               end
               default: parse_n = P_OP;
            endcase
            if (mem_go) begin
               state_n        = S_MEM_SETUP;
               ce_n[bank_q]   = 1'b1;
               ad_n[bank_q]   = addr_q;
               if (read_n) begin
                  oce_n[bank_q] = 1'b1;
               end else begin
                  wre_n[bank_q] = 1'b1;
                  din_n[bank_q] = byte_q;
               end
            end else begin
               state_n = S_ACK;
               ack_n   = 1'b1;
            end
         end
         S_MEM_SETUP: begin
            state_n        = S_MEM_CLKH;
            mclk_n[bank_q] = 1'b1;
         end
         S_MEM_CLKH: begin
            // Ack rises together with the falling bank clock so a memory byte acks at T+4
            state_n = S_MEM_CLKL;
            mclk_n  = '0;
            ce_n    = '0;
            wre_n   = '0;
            oce_n   = '0;
            ack_n   = 1'b1;
            if (read_q) dout_n = rd_data;
         end
         S_MEM_CLKL: begin
            state_n = S_ACK;
            addr_n  = addr_q + AW'(1);
         end
         S_ACK: begin
            if (!strobe_sync) begin
               state_n = S_IDLE;
               ack_n   = 1'b0;
            end
         end
         default: state_n = S_IDLE;
      endcase
   end

   always_ff @(posedge sysclk) begin
      if (arduino_reset) begin
         strobe_meta <= 1'b0;
         strobe_sync <= 1'b0;
         state_q     <= S_IDLE;
         parse_q     <= P_OP;
         byte_q      <= '0;
         bank_q      <= '0;
         addr_q      <= '0;
         read_q      <= 1'b0;
         ack_q       <= 1'b0;
         dout_q      <= '0;
         err_q       <= 1'b0;
         ce_q        <= '0;
         wre_q       <= '0;
         oce_q       <= '0;
         mclk_q      <= '0;
         ad_q        <= '0;
         din_q       <= '0;
      end else begin
         strobe_meta <= arduino_strobe;
         strobe_sync <= strobe_meta;
         state_q     <= state_n;
         parse_q     <= parse_n;
         byte_q      <= byte_n;
         bank_q      <= bank_n;
         addr_q      <= addr_n;
         read_q      <= read_n;
         ack_q       <= ack_n;
         dout_q      <= dout_n;
         err_q       <= err_n;
         ce_q        <= ce_n;
         wre_q       <= wre_n;
         oce_q       <= oce_n;
         mclk_q      <= mclk_n;
         ad_q        <= ad_n;
         din_q       <= din_n;
      end
   end

   assign arduino_ack  = ack_q;
   assign arduino_dout = dout_q;
   assign loader_error = err_q;

   assign mem_src_din = din_q[0];
   assign mem_src_ad  = ad_q[0];
   assign mem_src_ce  = ce_q[0];
   assign mem_src_wre = wre_q[0];
   assign mem_src_oce = oce_q[0];
   assign mem_src_clk = mclk_q[0];

   assign mem_key_din = din_q[1];
   assign mem_key_ad  = ad_q[1];
   assign mem_key_ce  = ce_q[1];
   assign mem_key_wre = wre_q[1];
   assign mem_key_oce = oce_q[1];
   assign mem_key_clk = mclk_q[1];

   assign mem_cmd_din = din_q[2];
   assign mem_cmd_ad  = ad_q[2];
   assign mem_cmd_ce  = ce_q[2];
   assign mem_cmd_wre = wre_q[2];
   assign mem_cmd_oce = oce_q[2];
   assign mem_cmd_clk = mclk_q[2];

   assign mem_dst_din = din_q[3];
   assign mem_dst_ad  = ad_q[3];
   assign mem_dst_ce  = ce_q[3];
   assign mem_dst_wre = wre_q[3];
   assign mem_dst_oce = oce_q[3];
   assign mem_dst_clk = mclk_q[3];

endmodule

// File: tb/tb_arduino_mem_loader.sv
// Directed bench for arduino_mem_loader: four behavioural banks, host byte handshake,
// latency/ack timing, bank isolation, address wrap, error flag and mid-cycle reset.
module tb_arduino_mem_loader;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        strobe = 1'b0;
   logic [7:0]  din = 8'h00;
   wire         ack;
   wire  [7:0]  dout;
   wire         err;

   wire  [3:0]  ce, wre, oce, mclk;
   wire  [13:0] mad [4];
   wire  [7:0]  mdin [4];
   logic [7:0]  mdout [4];

   int cmps = 0;
   int errs = 0;

   always #5 clk = ~clk;

   arduino_mem_loader dut (
      .sysclk(clk), .arduino_reset(rst), .arduino_strobe(strobe), .arduino_din(din),
      .arduino_ack(ack), .arduino_dout(dout), .loader_error(err),
      .mem_src_dout(mdout[0]), .mem_src_din(mdin[0]), .mem_src_ad(mad[0]), .mem_src_ce(ce[0]),
      .mem_src_wre(wre[0]), .mem_src_oce(oce[0]), .mem_src_clk(mclk[0]),
      .mem_key_dout(mdout[1]), .mem_key_din(mdin[1]), .mem_key_ad(mad[1]), .mem_key_ce(ce[1]),
      .mem_key_wre(wre[1]), .mem_key_oce(oce[1]), .mem_key_clk(mclk[1]),
      .mem_cmd_dout(mdout[2]), .mem_cmd_din(mdin[2]), .mem_cmd_ad(mad[2]), .mem_cmd_ce(ce[2]),
      .mem_cmd_wre(wre[2]), .mem_cmd_oce(oce[2]), .mem_cmd_clk(mclk[2]),
      .mem_dst_dout(mdout[3]), .mem_dst_din(mdin[3]), .mem_dst_ad(mad[3]), .mem_dst_ce(ce[3]),
      .mem_dst_wre(wre[3]), .mem_dst_oce(oce[3]), .mem_dst_clk(mclk[3])
   );

   // Background content of every never-written location
   function automatic logic [7:0] pat(input int b, input int a);
      return 8'(a) ^ 8'(a >> 8) ^ 8'(b * 59 + 7);
   endfunction

   logic [7:0]  arr [4][16384];
   bit          wr  [4][16384];
   int          pulses [4] = '{0, 0, 0, 0};
   int          act    [4] = '{0, 0, 0, 0};
   logic [13:0] last_ad  [4];
   logic [7:0]  last_din [4];
   logic [3:0]  prev = 4'b0;

   // Bank models act on the high phase of their own clock
   always @(negedge clk) begin
      for (int g = 0; g < 4; g++) begin
         if (ce[g] | wre[g] | oce[g] | mclk[g]) act[g] <= act[g] + 1;
         if (mclk[g] && !prev[g]) begin
            pulses[g]  <= pulses[g] + 1;
            last_ad[g] <= mad[g];
            if (ce[g] && wre[g]) begin
               arr[g][mad[g]] <= mdin[g];
               wr[g][mad[g]]  <= 1'b1;
               last_din[g]    <= mdin[g];
            end
            if (ce[g] && oce[g])
               mdout[g] <= wr[g][mad[g]] ? arr[g][mad[g]] : pat(g, int'(mad[g]));
         end
      end
      prev <= mclk;
   end

   // Present one byte; lat = posedges from strobe rise to ack seen, rel = posedges to ack low
   task automatic send_byte(input logic [7:0] b, output int lat, output int rel);
      @(negedge clk);
      din = b;
      strobe = 1'b1;
      lat = -1;
      for (int i = 1; i <= 20; i++) begin
         @(posedge clk); @(negedge clk);
         if (ack) begin lat = i; break; end
      end
      strobe = 1'b0;
      rel = -1;
      for (int i = 1; i <= 20; i++) begin
         @(posedge clk); @(negedge clk);
         if (!ack) begin rel = i; break; end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      cmps++; if (ack !== 1'b0)  begin errs++; $display("FAIL reset_ack got %b want 0", ack); end
      cmps++; if (dout !== 8'h00) begin errs++; $display("FAIL reset_dout got %h want 00", dout); end
      cmps++; if (err !== 1'b0)  begin errs++; $display("FAIL reset_err got %b want 0", err); end
      cmps++; if ({ce, wre, oce, mclk} !== 16'h0)
         begin errs++; $display("FAIL reset_ctl got %h want 0000", {ce, wre, oce, mclk}); end
      cmps++; if (mad[3] !== 14'h0 || mdin[3] !== 8'h00)
         begin errs++; $display("FAIL reset_bus got ad=%h din=%h want 0/0", mad[3], mdin[3]); end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_write();
      int lat, rel, p0, a0, a1, a2;
      send_byte(8'h10, lat, rel);
      cmps++; if (lat !== 4) begin errs++; $display("FAIL wr_op_lat got %0d want 4", lat); end
      cmps++; if (rel !== 3) begin errs++; $display("FAIL wr_op_rel got %0d want 3", rel); end
      send_byte(8'h03, lat, rel);
      send_byte(8'h20, lat, rel);
      send_byte(8'h12, lat, rel);
      send_byte(8'h34, lat, rel);
      send_byte(8'h30, lat, rel);
      cmps++; if (lat !== 4) begin errs++; $display("FAIL wr_30_lat got %0d want 4", lat); end
      p0 = pulses[3]; a0 = act[0]; a1 = act[1]; a2 = act[2];
      send_byte(8'hA5, lat, rel);
      cmps++; if (lat !== 6) begin errs++; $display("FAIL wr_data_lat got %0d want 6", lat); end
      cmps++; if (pulses[3] - p0 !== 1)
         begin errs++; $display("FAIL wr_pulses got %0d want 1", pulses[3] - p0); end
      cmps++; if (last_ad[3] !== 14'h1234 || last_din[3] !== 8'hA5)
         begin errs++; $display("FAIL wr_bus got ad=%h din=%h want 1234/a5", last_ad[3], last_din[3]); end
      cmps++; if (arr[3][14'h1234] !== 8'hA5)
         begin errs++; $display("FAIL wr_mem got %h want a5", arr[3][14'h1234]); end
      cmps++; if (act[0] != a0 || act[1] != a1 || act[2] != a2)
         begin errs++; $display("FAIL wr_isolation got %0d/%0d/%0d want 0/0/0", act[0]-a0, act[1]-a1, act[2]-a2); end
      send_byte(8'h40, lat, rel);
      cmps++; if (dout !== pat(3, 14'h1235))
         begin errs++; $display("FAIL wr_next_addr got %h want %h", dout, pat(3, 14'h1235)); end
   endtask

   task automatic test_wrap();
      int lat, rel;
      send_byte(8'h10, lat, rel);
      send_byte(8'h01, lat, rel);
      send_byte(8'h20, lat, rel);
      send_byte(8'hFF, lat, rel);
      send_byte(8'hFF, lat, rel);
      send_byte(8'h40, lat, rel);
      cmps++; if (lat !== 6) begin errs++; $display("FAIL wrap_lat1 got %0d want 6", lat); end
      cmps++; if (dout !== pat(1, 14'h3FFF))
         begin errs++; $display("FAIL wrap_rd1 got %h want %h", dout, pat(1, 14'h3FFF)); end
      send_byte(8'h40, lat, rel);
      cmps++; if (lat !== 6) begin errs++; $display("FAIL wrap_lat2 got %0d want 6", lat); end
      cmps++; if (dout !== pat(1, 0))
         begin errs++; $display("FAIL wrap_rd2 got %h want %h", dout, pat(1, 0)); end
      cmps++; if (err !== 1'b0) begin errs++; $display("FAIL wrap_err got %b want 0", err); end
   endtask

   task automatic test_error();
      int lat, rel;
      send_byte(8'h7E, lat, rel);
      cmps++; if (lat !== 4) begin errs++; $display("FAIL err_lat got %0d want 4", lat); end
      cmps++; if (err !== 1'b1) begin errs++; $display("FAIL err_set got %b want 1", err); end
      send_byte(8'h00, lat, rel);
      cmps++; if (err !== 1'b1) begin errs++; $display("FAIL err_nop got %b want 1", err); end
      send_byte(8'h01, lat, rel);
      cmps++; if (err !== 1'b0) begin errs++; $display("FAIL err_clear got %b want 0", err); end
   endtask

   task automatic test_hold();
      int lat, rel, drops, p1;
      p1 = pulses[1];
      drops = 0;
      lat = -1;
      @(negedge clk);
      din = 8'h40;
      strobe = 1'b1;
      for (int i = 1; i <= 20; i++) begin
         @(posedge clk); @(negedge clk);
         if (ack && lat < 0) lat = i;
         if (lat >= 0 && !ack) drops++;
      end
      strobe = 1'b0;
      rel = -1;
      for (int i = 1; i <= 20; i++) begin
         @(posedge clk); @(negedge clk);
         if (!ack) begin rel = i; break; end
      end
      cmps++; if (lat !== 6) begin errs++; $display("FAIL hold_lat got %0d want 6", lat); end
      cmps++; if (drops !== 0) begin errs++; $display("FAIL hold_ack_drop got %0d want 0", drops); end
      cmps++; if (rel !== 3) begin errs++; $display("FAIL hold_rel got %0d want 3", rel); end
      cmps++; if (pulses[1] - p1 !== 1)
         begin errs++; $display("FAIL hold_pulses got %0d want 1", pulses[1] - p1); end
      cmps++; if (dout !== pat(1, 1))
         begin errs++; $display("FAIL hold_rd got %h want %h", dout, pat(1, 1)); end
      send_byte(8'h40, lat, rel);
      cmps++; if (dout !== pat(1, 2))
         begin errs++; $display("FAIL hold_next got %h want %h", dout, pat(1, 2)); end
   endtask

   task automatic test_reset_mid();
      int lat, rel, seen, p0;
      send_byte(8'h10, lat, rel);
      send_byte(8'h03, lat, rel);
      send_byte(8'h30, lat, rel);
      @(negedge clk);
      din = 8'h5A;
      strobe = 1'b1;
      seen = 0;
      for (int i = 1; i <= 12; i++) begin
         @(posedge clk); @(negedge clk);
         if (mclk[3]) begin seen = 1; break; end
      end
      cmps++; if (seen !== 1) begin errs++; $display("FAIL mid_clkh got %0d want 1", seen); end
      rst = 1'b1;
      strobe = 1'b0;
      @(posedge clk); @(negedge clk);
      cmps++; if (mclk[3] !== 1'b0 || ce[3] !== 1'b0 || wre[3] !== 1'b0)
         begin errs++; $display("FAIL mid_abort got clk=%b ce=%b wre=%b want 0", mclk[3], ce[3], wre[3]); end
      cmps++; if (dout !== 8'h00 || ack !== 1'b0)
         begin errs++; $display("FAIL mid_rst_out got dout=%h ack=%b want 00/0", dout, ack); end
      rst = 1'b0;
      repeat (3) @(negedge clk);
      p0 = pulses[0];
      send_byte(8'h40, lat, rel);
      cmps++; if (lat !== 6) begin errs++; $display("FAIL mid_rd_lat got %0d want 6", lat); end
      cmps++; if (pulses[0] - p0 !== 1)
         begin errs++; $display("FAIL mid_src_pulse got %0d want 1", pulses[0] - p0); end
      cmps++; if (dout !== pat(0, 0))
         begin errs++; $display("FAIL mid_rd got %h want %h", dout, pat(0, 0)); end
   endtask

   task automatic test_bank_mask();
      int lat, rel, p2, a0, a1, a3;
      send_byte(8'h10, lat, rel);
      send_byte(8'hFE, lat, rel);
      send_byte(8'h30, lat, rel);
      p2 = pulses[2]; a0 = act[0]; a1 = act[1]; a3 = act[3];
      send_byte(8'h11, lat, rel);
      cmps++; if (pulses[2] - p2 !== 1)
         begin errs++; $display("FAIL mask_pulses got %0d want 1", pulses[2] - p2); end
      cmps++; if (last_ad[2] !== 14'h0001 || last_din[2] !== 8'h11)
         begin errs++; $display("FAIL mask_bus got ad=%h din=%h want 0001/11", last_ad[2], last_din[2]); end
      cmps++; if (arr[2][1] !== 8'h11)
         begin errs++; $display("FAIL mask_mem got %h want 11", arr[2][1]); end
      cmps++; if (act[0] != a0 || act[1] != a1 || act[3] != a3)
         begin errs++; $display("FAIL mask_isolation got %0d/%0d/%0d want 0/0/0", act[0]-a0, act[1]-a1, act[3]-a3); end
   endtask

   initial begin
      test_reset();
      test_write();
      test_wrap();
      test_error();
      test_hold();
      test_reset_mid();
      test_bank_mask();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmps, errs);
      $finish;
   end

endmodule
